uart_cmd_ctrl: RTL and testbench

Host-command sequencer that sits directly behind the UART receiver and in front of the TPU's buffer/control logic. Consumes the received byte stream (data/valid/framing-error strobes) and frames packets of the form SYNC, OPCODE, ADDR, LEN, LEN payload bytes, CHECKSUM. Payload bytes stream out as staged writes with auto-incrementing address. A validated command is then presented on a valid/ready interface; downstream commits only on acceptance.

---
 rtl/uart_cmd_ctrl_if.sv | 29 ++
 rtl/uart_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream, staged-write and command handshake bundle between the UART
// receiver, uart_cmd_ctrl and the downstream buffer/control logic.
interface uart_cmd_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_framing_error;

   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;

   logic       cmd_valid;
   logic [7:0] cmd_opcode;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_len;
   logic       cmd_ready;

   modport master (
      input  rx_data, rx_valid, rx_framing_error, cmd_ready,
      output wr_valid, wr_addr, wr_data,
      output cmd_valid, cmd_opcode, cmd_addr, cmd_len
   );

   modport slave (
      output rx_data, rx_valid, rx_framing_error, cmd_ready,
      input  wr_valid, wr_addr, wr_data,
      input  cmd_valid, cmd_opcode, cmd_addr, cmd_len
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frames SYNC/OPC/ADDR/LEN/payload/CSUM packets from the UART byte stream, streams
// the payload out as staged writes and presents the validated command on valid/ready.
module uart_cmd_ctrl #(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 1_000_000
) (
   input  logic            clk,
   input  logic            rst,
   uart_cmd_ctrl_if.master bus,
   output logic            err_checksum,
   output logic            err_timeout,
   output logic            err_framing,
   output logic            err_overrun,
   output logic            busy
);

   // state | meaning
   // HUNT  | idle, waiting for SYNC_BYTE
   // OPC   | expecting opcode byte
   // ADR   | expecting base address byte
   // LEN   | expecting payload length byte
   // PAY   | streaming payload bytes out as staged writes
   // CSUM  | expecting checksum byte
   // ISSUE | command presented, waiting for cmd_ready
   typedef enum logic [2:0] {HUNT, OPC, ADR, LEN, PAY, CSUM, ISSUE} state_t;

   localparam int            TW       = $clog2(TIMEOUT_CLKS);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CLKS - 1);

   state_t        state;
   logic [7:0]    csum;
   logic [7:0]    idx;
   logic [TW-1:0] tmr;
   logic          accept;

   assign accept = bus.cmd_valid && bus.cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= HUNT;
         csum           <= 8'h00;
         idx            <= 8'h00;
         tmr            <= '0;
         bus.wr_valid   <= 1'b0;
         bus.wr_addr    <= 8'h00;
         bus.wr_data    <= 8'h00;
         bus.cmd_valid  <= 1'b0;
         bus.cmd_opcode <= 8'h00;
         bus.cmd_addr   <= 8'h00;
         bus.cmd_len    <= 8'h00;
         err_checksum   <= 1'b0;
         err_timeout    <= 1'b0;
         err_framing    <= 1'b0;
         err_overrun    <= 1'b0;
         busy           <= 1'b0;
      end else begin
         bus.wr_valid <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_framing  <= 1'b0;
         err_overrun  <= 1'b0;

         if (state == ISSUE) begin
            // The pending command survives line errors; only acceptance releases it.
            if (bus.rx_framing_error)
               err_framing <= 1'b1;
            else if (bus.rx_valid)
               err_overrun <= 1'b1;
            if (accept) begin
               bus.cmd_valid <= 1'b0;
               state         <= HUNT;
               busy          <= 1'b0;
            end
         end else if (bus.rx_framing_error) begin
            err_framing <= 1'b1;
            state       <= HUNT;
            busy        <= 1'b0;
         end else begin
            case (state)
               HUNT: begin
                  if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                     state <= OPC;
                     busy  <= 1'b1;
                     csum  <= 8'h00;
                     tmr   <= TMR_LOAD;
                  end
               end
               OPC, ADR, LEN, PAY, CSUM: begin
                  if (bus.rx_valid) begin
                     tmr <= TMR_LOAD;
                     case (state)
                        OPC: begin
                           bus.cmd_opcode <= bus.rx_data;
                           csum           <= csum ^ bus.rx_data;
                           state          <= ADR;
                        end
                        ADR: begin
                           bus.cmd_addr <= bus.rx_data;
                           csum         <= csum ^ bus.rx_data;
                           state        <= LEN;
                        end
                        LEN: begin
                           bus.cmd_len <= bus.rx_data;
                           csum        <= csum ^ bus.rx_data;
                           idx         <= 8'h00;
                           state       <= (bus.rx_data != 8'h00) ? PAY : CSUM;
                        end
                        PAY: begin
                           bus.wr_valid <= 1'b1;
                           bus.wr_addr  <= bus.cmd_addr + idx;
                           bus.wr_data  <= bus.rx_data;
                           csum         <= csum ^ bus.rx_data;
                           idx          <= idx + 8'd1;
                           if (idx == bus.cmd_len - 8'd1)
                              state <= CSUM;
                        end
                        CSUM: begin
                           if (bus.rx_data == csum) begin
                              state         <= ISSUE;
                              bus.cmd_valid <= 1'b1;
                           end else begin
                              err_checksum <= 1'b1;
                              state        <= HUNT;
                              busy         <= 1'b0;
                           end
                        end
                        default: begin
                           state <= HUNT;
                           busy  <= 1'b0;
                        end
                     endcase
                  end else if (tmr == '0) begin
                     err_timeout <= 1'b1;
                     state       <= HUNT;
                     busy        <= 1'b0;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               default: begin
                  state <= HUNT;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed and random packets, expectations derived from
// packet contents (writes, checksum, command) and timing rules.
module tb_uart_cmd_ctrl;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TMO  = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_checksum, err_timeout, err_framing, err_overrun, busy;

   uart_cmd_ctrl_if bus ();

   uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .err_checksum (err_checksum),
      .err_timeout  (err_timeout),
      .err_framing  (err_framing),
      .err_overrun  (err_overrun),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // observed activity, sampled mid-cycle
   logic [15:0] wr_q[$];
   logic [23:0] cv_q[$];
   logic [23:0] acc_q[$];
   int n_csum = 0, n_tmo = 0, n_frm = 0, n_ovr = 0, n_multi = 0, tmo_cyc = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_valid) wr_q.push_back({bus.wr_addr, bus.wr_data});
         if (bus.cmd_valid) begin
            cv_q.push_back({bus.cmd_opcode, bus.cmd_addr, bus.cmd_len});
            if (bus.cmd_ready) acc_q.push_back({bus.cmd_opcode, bus.cmd_addr, bus.cmd_len});
         end
         if (err_checksum) n_csum++;
         if (err_framing)  n_frm++;
         if (err_overrun)  n_ovr++;
         if (err_timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
         end
         if ($countones({err_checksum, err_timeout, err_framing, err_overrun}) > 1) n_multi++;
      end
   end

   logic [7:0] pay[$];
   int         last_edge;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      last_edge    = cyc;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic send_garbage(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         if (b == SYNC) b = 8'h00;
         send_byte(b);
      end
   endtask

   function automatic logic [7:0] xor_sum(input logic [7:0] opc, input logic [7:0] addr);
      logic [7:0] s;
      s = opc ^ addr ^ 8'(pay.size());
      foreach (pay[i]) s ^= pay[i];
      return s;
   endfunction

   // Sends one packet built from opc/addr/pay and checksum byte cs, then checks
   // writes, command and error pulses against what the packet contents imply.
   task automatic run_packet(input logic [7:0] opc, input logic [7:0] addr, input logic [7:0] cs,
                             input bit rdy, input int gmax, input bit ovr);
      int w0, a0, v0, c0, f0, o0, t0, m0, len;
      bit good;
      logic [23:0] exp_cmd;
      len     = pay.size();
      good    = (cs == xor_sum(opc, addr));
      exp_cmd = {opc, addr, 8'(len)};
      w0 = wr_q.size(); a0 = acc_q.size(); v0 = cv_q.size();
      c0 = n_csum; f0 = n_frm; o0 = n_ovr; t0 = n_tmo; m0 = n_multi;
      bus.cmd_ready = rdy;
      send_byte(SYNC);
      chk("busy_pkt", busy, 1);
      idle($urandom_range(0, gmax));
      send_byte(opc);         idle($urandom_range(0, gmax));
      send_byte(addr);        idle($urandom_range(0, gmax));
      send_byte(8'(len));     idle($urandom_range(0, gmax));
      foreach (pay[i]) begin
         send_byte(pay[i]);
         idle($urandom_range(0, gmax));
      end
      send_byte(cs);
      if (good && !rdy) begin
         for (int k = 0; k < 20 && !bus.cmd_valid; k++) tick();
         chk("cmd_valid_seen", bus.cmd_valid, 1);
         if (ovr) begin
            send_byte(SYNC);
            idle(1);
            chk("ovr_pulse", n_ovr - o0, 1);
            chk("ovr_valid_held", bus.cmd_valid, 1);
            chk("ovr_busy", busy, 1);
         end
         idle($urandom_range(0, 3));
         bus.cmd_ready = 1'b1;
      end
      idle(3);
      bus.cmd_ready = 1'b0;
      chk("wr_count", wr_q.size() - w0, len);
      for (int i = 0; i < len && w0 + i < wr_q.size(); i++) begin
         chk("wr_addr", wr_q[w0+i][15:8], 8'(addr + i));
         chk("wr_data", wr_q[w0+i][7:0], pay[i]);
      end
      chk("cmd_accepts", acc_q.size() - a0, good);
      if (good && acc_q.size() > a0) chk("cmd_accepted", acc_q[a0], exp_cmd);
      for (int i = v0; i < cv_q.size(); i++) chk("cmd_hold", cv_q[i], exp_cmd);
      if (good && rdy) chk("valid_cycles", cv_q.size() - v0, 1);
      chk("err_checksum", n_csum - c0, !good);
      chk("err_overrun", n_ovr - o0, ovr && good && !rdy);
      chk("err_other", (n_frm - f0) + (n_tmo - t0), 0);
      chk("err_multi", n_multi - m0, 0);
      chk("busy_end", busy, 0);
      chk("cmd_valid_end", bus.cmd_valid, 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int f0, t0, w0, e0;
      logic [7:0] opc, addr;
      bit rdy, bad;

      bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_framing_error = 1'b0; bus.cmd_ready = 1'b0;
      idle(3);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {bus.wr_valid, bus.cmd_valid}, 0);
      chk("rst_errs", {err_checksum, err_timeout, err_framing, err_overrun}, 0);
      chk("rst_cmd", {bus.cmd_opcode, bus.cmd_addr, bus.cmd_len}, 0);
      chk("rst_wr", {bus.wr_addr, bus.wr_data}, 0);
      rst = 1'b0;
      idle(2);

      // basic packet
      pay = '{8'h11, 8'h22, 8'h33};
      run_packet(8'h01, 8'h10, 8'h12, 1'b1, 0, 1'b0);

      // address wrap FE, FF, 00
      pay = '{8'hAA, 8'hBB, 8'hCC};
      run_packet(8'h05, 8'hFE, xor_sum(8'h05, 8'hFE), 1'b1, 1, 1'b0);

      // leading garbage, zero length
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("garbage_busy", busy, 0);
      pay = {};
      run_packet(8'h02, 8'h40, 8'h42, 1'b1, 0, 1'b0);

      // bad checksum then good packet
      pay = '{8'h11, 8'h22, 8'h33};
      run_packet(8'h01, 8'h10, 8'h13, 1'b1, 0, 1'b0);
      run_packet(8'h01, 8'h10, 8'h12, 1'b1, 2, 1'b0);

      // inter-byte timeout, then no further timeout while hunting
      t0 = n_tmo;
      send_byte(SYNC);
      send_byte(8'h01);
      e0 = last_edge;
      for (int k = 0; k < 300 && n_tmo == t0; k++) tick();
      chk("tmo_seen", n_tmo - t0, 1);
      chk("tmo_delay", tmo_cyc - e0, TMO);
      chk("tmo_busy", busy, 0);
      idle(150);
      chk("tmo_pulses", n_tmo - t0, 1);

      // framing mid-payload
      f0 = n_frm; w0 = wr_q.size();
      send_byte(SYNC); send_byte(8'h01); send_byte(8'h10); send_byte(8'h05);
      send_byte(8'h5A); send_byte(8'h6B);
      bus.rx_framing_error = 1'b1;
      tick();
      bus.rx_framing_error = 1'b0;
      idle(2);
      chk("frm_pulse", n_frm - f0, 1);
      chk("frm_busy", busy, 0);
      chk("frm_writes", wr_q.size() - w0, 2);

      // framing together with a SYNC byte: byte is dropped
      f0 = n_frm;
      bus.rx_data = SYNC; bus.rx_valid = 1'b1; bus.rx_framing_error = 1'b1;
      tick();
      bus.rx_valid = 1'b0; bus.rx_framing_error = 1'b0;
      idle(2);
      chk("frm_sync_pulse", n_frm - f0, 1);
      chk("frm_sync_busy", busy, 0);

      // overrun while command pending
      pay = '{8'h11, 8'h22, 8'h33};
      run_packet(8'h01, 8'h10, 8'h12, 1'b0, 0, 1'b1);

      // reset mid-payload
      send_byte(SYNC); send_byte(8'h01); send_byte(8'h10); send_byte(8'h05);
      send_byte(8'h77); send_byte(8'h88);
      rst = 1'b1;
      #1;
      chk("midrst_wr", {bus.wr_valid, bus.wr_addr, bus.wr_data}, 0);
      chk("midrst_cmd", {bus.cmd_valid, bus.cmd_opcode, bus.cmd_addr, bus.cmd_len}, 0);
      chk("midrst_busy", busy, 0);
      idle(2);
      rst = 1'b0;
      idle(2);
      pay = '{8'h9C};
      run_packet(8'h07, 8'h33, xor_sum(8'h07, 8'h33), 1'b1, 0, 1'b0);

      // randomized packets
      for (int n = 0; n < 25; n++) begin
         send_garbage($urandom_range(0, 2));
         opc  = 8'($urandom);
         addr = ($urandom_range(0, 3) == 0) ? 8'(8'hFA + $urandom_range(0, 5)) : 8'($urandom);
         pay  = {};
         for (int i = $urandom_range(0, 6); i > 0; i--)
            pay.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
         bad = ($urandom_range(0, 3) == 0);
         rdy = $urandom_range(0, 1);
         run_packet(opc, addr, xor_sum(opc, addr) ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00),
                    rdy, $urandom_range(0, 3), !rdy && $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
